// File: rtl/rx_frame_pkg.sv
// Shared encodings and defaults for the oversampled serial frame receiver.
// State values, default widths and the bit_idx landmarks live here.
package rx_frame_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

`ifdef PARITY_CHECK_EN
    localparam bit PARITY_ON = 1'b1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;
`else
    localparam bit PARITY_ON = 1'b0;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;
`endif

    localparam logic [3:0] IDX_START = 4'd0;

    function automatic logic [3:0] idx_parity(input int data_bits);
        return 4'(data_bits + 1);
    endfunction

    function automatic logic [3:0] idx_stop(input int data_bits);
        return 4'(data_bits + 1 + (PARITY_ON ? 1 : 0));
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_bit_sample_counter.sv
// Mid-bit sample strobe and bit index generator for the frame receiver.
// Latency: strobe OVERSAMPLE/2 ticks after run rises, then every OVERSAMPLE ticks.
// Backpressure: none; free-running while run is high, held cleared otherwise.
module bit_sample_counter
    import rx_frame_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       sr_clk,
    input  logic       reset,
    input  logic       run,
    output logic       strobe,
    output logic [3:0] bit_idx
);

    localparam int              CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   FULL_LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt;
    logic          half;
    logic [3:0]    idx_q;

    // The first strobe lands mid start bit; afterwards the count is realigned
    // so every later strobe is a full bit period on, i.e. mid-bit again.
    assign strobe  = run && (cnt == (half ? HALF_LAST : FULL_LAST));
    assign bit_idx = run ? idx_q : IDX_START;

    always_ff @(posedge sr_clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            half  <= 1'b1;
            idx_q <= IDX_START;
        end else if (!run) begin
            cnt   <= '0;
            half  <= 1'b1;
            idx_q <= IDX_START;
        end else if (strobe) begin
            cnt   <= '0;
            half  <= 1'b0;
            idx_q <= idx_q + 4'd1;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Oversampled serial frame receiver with valid/ready output; optional even parity via PARITY_CHECK_EN.
// Latency: rx_valid rises one sr_clk after the stop-bit mid sample (2-cycle input sync ahead of that).
// Backpressure: one-word holding register; a good frame arriving while it is full sets sticky overrun.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 sr_clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [3:0]           bit_idx
);

    logic                 rx_meta;
    logic                 rxs;
    logic                 armed;
    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic                 strobe;
    logic                 run;
    logic                 good_stop;
    logic                 handshake;

    // Sync flops reset low so a line that never went high cannot start a frame.
    always_ff @(posedge sr_clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b0;
            rxs     <= 1'b0;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
            if (rxs) armed <= 1'b1;
        end
    end

    assign run = (state != IDLE) && (state != BREAK);

    bit_sample_counter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_sample_counter (
        .sr_clk  (sr_clk),
        .reset   (reset),
        .run     (run),
        .strobe  (strobe),
        .bit_idx (bit_idx)
    );

`ifdef PARITY_CHECK_EN
    logic par_bad;
    logic parity_err_q;
    assign parity_err = parity_err_q;
    assign good_stop  = strobe && (state == STOP) && rxs && !par_bad;
`else
    assign parity_err = 1'b0;
    assign good_stop  = strobe && (state == STOP) && rxs;
`endif

    assign handshake = rx_valid && rx_ready;

    always_ff @(posedge sr_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            shreg        <= '0;
            frame_err    <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state   <= START;
                        busy    <= 1'b1;
`ifdef PARITY_CHECK_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (strobe) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (strobe) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == 4'(DATA_BITS)) begin
`ifdef PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    // Even parity: the received bit must equal the XOR of the data bits.
                    if (strobe) begin
                        par_bad <= (rxs != ^shreg);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (strobe) begin
`ifdef PARITY_CHECK_EN
                        parity_err_q <= par_bad;
`endif
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A completing frame may refill the holding register in the same cycle it drains.
    always_ff @(posedge sr_clk or negedge reset) begin
        if (!reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (good_stop) begin
                if (!rx_valid || handshake) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (handshake) begin
                rx_valid <= 1'b0;
            end
            if (handshake) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed plus randomized bench for rx_frame_ctrl against a word-level expectation list.
module tb_rx_frame_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef PARITY_CHECK_EN
    localparam int STOP_IDX = DB + 2;
`else
    localparam int STOP_IDX = DB + 1;
`endif

    logic          sr_clk   = 1'b0;
    logic          reset    = 1'b0;
    logic          rx_in    = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;
    logic [3:0]    bit_idx;

    int checks = 0;
    int errors = 0;

    rx_frame_ctrl #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .sr_clk     (sr_clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy),
        .bit_idx    (bit_idx)
    );

    always #5 sr_clk = ~sr_clk;

    // Observation counters, written only here and read as deltas by the sequence.
    int            valid_cycles = 0;
    int            busy_cycles  = 0;
    int            fe_pulses    = 0;
    int            fe_run       = 0;
    int            fe_max       = 0;
    int            pe_pulses    = 0;
    int            pe_run       = 0;
    int            max_idx      = 0;
    logic [DB-1:0] words[$];

    always @(negedge sr_clk) begin
        if (rx_valid) valid_cycles++;
        if (busy) busy_cycles++;
        if (rx_valid && rx_ready) words.push_back(rx_data);
        if (frame_err) begin
            fe_run++;
            if (fe_run == 1) fe_pulses++;
            if (fe_run > fe_max) fe_max = fe_run;
        end else begin
            fe_run = 0;
        end
        if (parity_err) begin
            pe_run++;
            if (pe_run == 1) pe_pulses++;
        end else begin
            pe_run = 0;
        end
        if (int'(bit_idx) > max_idx) max_idx = int'(bit_idx);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sr_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        cyc(OS);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        cyc(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
        send_bit(par);
`else
        if (par === 1'bx) rx_in = 1'b1;
`endif
        send_bit(stop_bit);
    endtask

    int            vc0, bc0, fe0, pe0, nw0;
    int            exp_cnt;
    logic [DB-1:0] exp_words[$];
    logic [DB-1:0] d;
    logic          stop_bit;

    initial begin
        // Reset state, then release with the line still low: no frame may start.
        cyc(3);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idx", 32'(bit_idx), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_perr", 32'(parity_err), 0);
        bc0 = busy_cycles;
        reset = 1'b1;
        cyc(40);
        chk("low_after_release_busy", 32'(busy_cycles - bc0), 0);
        idle(20);

        // Good frame, consumer always ready.
        rx_ready = 1'b1;
        vc0 = valid_cycles; fe0 = fe_pulses; pe0 = pe_pulses; nw0 = words.size();
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(10);
        chk("a5_valid_cycles", 32'(valid_cycles - vc0), 1);
        chk("a5_word_count", 32'(words.size() - nw0), 1);
        chk("a5_data", 32'(words[nw0]), 32'h A5);
        chk("a5_ferr", 32'(fe_pulses - fe0), 0);
        chk("a5_perr", 32'(pe_pulses - pe0), 0);
        chk("a5_busy", 32'(busy), 0);
        chk("a5_max_idx", 32'(max_idx), 32'(STOP_IDX));

        // Short glitch: start bit rejected at its mid sample.
        vc0 = valid_cycles; fe0 = fe_pulses; bc0 = busy_cycles;
        rx_in = 1'b0;
        cyc(4);
        idle(30);
        chk("glitch_busy_cycles", 32'(busy_cycles - bc0), 32'(OS / 2));
        chk("glitch_busy", 32'(busy), 0);
        chk("glitch_valid", 32'(valid_cycles - vc0), 0);
        chk("glitch_ferr", 32'(fe_pulses - fe0), 0);

        // Stop bit low: frame error, then BREAK until the line returns high.
        vc0 = valid_cycles; fe0 = fe_pulses;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        cyc(40);
        chk("brk_ferr_pulses", 32'(fe_pulses - fe0), 1);
        chk("brk_ferr_width", 32'(fe_max), 1);
        chk("brk_valid", 32'(valid_cycles - vc0), 0);
        chk("brk_busy_held", 32'(busy), 1);
        idle(5);
        chk("brk_exit_busy", 32'(busy), 0);

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11);
        idle(10);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(10);
        chk("ovr_valid", 32'(rx_valid), 1);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_flag", 32'(overrun), 1);
        nw0 = words.size();
        rx_ready = 1'b1;
        cyc(1);
        chk("ovr_drain_valid", 32'(rx_valid), 0);
        chk("ovr_drain_flag", 32'(overrun), 0);
        cyc(5);
        chk("ovr_drain_word", 32'(words[nw0]), 32'h11);
        chk("ovr_drain_count", 32'(words.size() - nw0), 1);

        // Reset in the middle of a frame, then a clean frame.
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        cyc(3);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_idx", 32'(bit_idx), 0);
        chk("midrst_data", 32'(rx_data), 0);
        chk("midrst_valid", 32'(rx_valid), 0);
        rx_in = 1'b1;
        cyc(2);
        reset = 1'b1;
        idle(20);
        nw0 = words.size(); fe0 = fe_pulses; pe0 = pe_pulses;
        send_frame(8'h0F, 1'b1, ^8'h0F);
        idle(10);
        chk("midrst_new_count", 32'(words.size() - nw0), 1);
        chk("midrst_new_data", 32'(words[nw0]), 32'h0F);
        chk("midrst_new_ferr", 32'(fe_pulses - fe0), 0);
        chk("midrst_new_perr", 32'(pe_pulses - pe0), 0);

`ifdef PARITY_CHECK_EN
        vc0 = valid_cycles; pe0 = pe_pulses;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        chk("par_bad_pulse", 32'(pe_pulses - pe0), 1);
        chk("par_bad_valid", 32'(valid_cycles - vc0), 0);
        nw0 = words.size(); pe0 = pe_pulses;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        chk("par_ok_perr", 32'(pe_pulses - pe0), 0);
        chk("par_ok_data", 32'(words[nw0]), 32'h07);
`endif

        // Randomized frames; expected words are the data of frames with a high stop bit.
        nw0 = words.size();
        exp_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            d        = DB'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            fe0      = fe_pulses;
            send_frame(d, stop_bit, ^d);
            if (stop_bit) begin
                exp_words.push_back(d);
                exp_cnt++;
            end
            idle($urandom_range(2, 30));
            chk("rnd_ferr", 32'(fe_pulses - fe0), stop_bit ? 0 : 1);
            chk("rnd_count", 32'(words.size() - nw0), 32'(exp_cnt));
            if (stop_bit && (words.size() - nw0) == exp_cnt)
                chk("rnd_data", 32'(words[nw0 + exp_cnt - 1]), 32'(exp_words[exp_cnt - 1]));
        end

        chk("final_ferr_width", 32'(fe_max), 1);
        chk("final_max_idx", 32'(max_idx), 32'(STOP_IDX));
        chk("final_overrun", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter OVERSAMPLE, default 16: sr_clk ticks per serial bit; even, 8..64.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; 5..8.
REQ-003 sr_clk  in  1  single clock, OVERSAMPLE x baud rate.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 rx_in  in  1  serial line, idle high, LSB first, asynchronous to sr_clk.
REQ-006 rx_data  out  DATA_BITS  last good received word.
REQ-007 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-008 rx_ready  in  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1 at a sr_clk rising edge.
REQ-009 frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-010 parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without PARITY_CHECK_EN).
REQ-011 overrun  out  1  sticky: a good frame was lost because rx_valid was still set.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 bit_idx  out  4  index of the bit being received: 0 = start bit, 1..DATA_BITS = data, then parity, then stop.

Function
REQ-014 rx_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (rxs); 2-cycle input latency.
REQ-015 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-016 IDLE->START on rxs=0; tick counter cleared.
REQ-017 START: at tick OVERSAMPLE/2-1, rxs=0 -> DATA with counter realigned to mid-bit; rxs=1 -> IDLE (glitch rejected, no error pulse).
REQ-018 DATA: sample rxs every OVERSAMPLE ticks at mid-bit; shift into bit DATA_BITS-1 of a shift register moving right, so the first data bit lands in bit 0 after DATA_BITS samples; after DATA_BITS samples -> PARITY or STOP.
REQ-019 STOP: sample at mid-bit. rxs=1 and no parity error -> load rx_data, set rx_valid on the next edge, go to IDLE. rxs=0 -> pulse frame_err, discard data, go to BREAK.
REQ-020 BREAK: stay until rxs=1, then go to IDLE.
REQ-021 Handshake: rx_valid&&rx_ready clears rx_valid on the next edge; rx_data stays stable while rx_valid=1.
REQ-022 A good frame completing while rx_valid=1 and rx_ready=0 SHALL set overrun and keep the old rx_data.
REQ-023 A good frame completing in the same cycle as a handshake SHALL load the new data, keep rx_valid=1, and not set overrun.
REQ-024 overrun SHALL clear on the next successful handshake.
REQ-025 bit_idx SHALL update on each mid-bit sample and read 0 in IDLE.

Reset
REQ-026 reset=0 SHALL immediately force the state to IDLE and clear the counters, the shift register and rx_data, and force rx_valid, frame_err, parity_err, overrun and busy to 0; this also applies in the middle of a frame.
REQ-027 After release, the first frame is accepted only after rxs has been sampled high at least once.

Configuration
REQ-028 With macro PARITY_CHECK_EN defined, one even-parity bit SHALL follow the data bits in state PARITY; a mismatch SHALL pulse parity_err in the STOP-sample cycle, and the word is discarded.
REQ-029 Without PARITY_CHECK_EN, the PARITY state and its logic SHALL be absent, the frame SHALL be start + data + stop, and parity_err SHALL be held at 0.

Structure
REQ-030 Package rx_frame_pkg SHALL hold the state encoding, the OVERSAMPLE and DATA_BITS defaults, and the bit_idx values for start, parity and stop.
REQ-031 Sub-module bit_sample_counter SHALL generate the mid-bit sample strobe and bit_idx; the FSM, shift register and handshake stay in rx_frame_ctrl.

Verification
REQ-032 Send 0xA5 with stop bit 1, rx_ready=1 -> rx_valid is high 1 cycle, rx_data=0xA5, no errors.
REQ-033 rx_in low for 4 ticks then high -> state returns to IDLE, rx_valid=0, frame_err=0.
REQ-034 Send 0x3C with stop bit 0 -> frame_err pulses 1 cycle, rx_valid=0, state stays BREAK until the line goes high.
REQ-035 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; raise rx_ready -> rx_valid=0 and overrun=0 on the next edge.
REQ-036 Assert reset at data bit 4 of 0xFF, release, send 0x0F -> rx_data=0x0F, no errors.
REQ-037 With PARITY_CHECK_EN, send 0x07 with parity bit 0 -> parity_err pulses, rx_valid=0; repeat with parity bit 1 -> rx_data=0x07.
